// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM state encoding and default widths/depths.
// Pure declarations; no timing. No handshake of its own.
package uart_pkg;

    localparam int DBITS_DEF        = 8;
    localparam int FEEDER_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy register and registered empty/full flags.
// Write stores on the edge; head word is visible combinationally from the read pointer.
// Caller must gate push with !full_o and pop with !empty_o; flags track count after each edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          empty_q;
    logic          full_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: a cleared pointer pair makes every old entry unreachable.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO + launch FSM feeding a UART transmitter; optional stats via UART_TX_FEEDER_STATS_EN.
// Latency: a byte written to an empty FIFO reaches tx_start two edges later (store, then launch).
// Backpressure: wr_ready = !fifo_full; the FIFO drains only when tx_on rises during a launch.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DBITS         = DBITS_DEF,
    parameter int DEPTH         = FEEDER_DEPTH_DEF,
    parameter int START_HOLD    = 5,
    parameter int START_TIMEOUT = 4096,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DBITS-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [DBITS-1:0]         tx_data,
    output logic                     tx_start,
    input  logic                     tx_on,
`ifdef UART_TX_FEEDER_STATS_EN
    output logic [31:0]              bytes_sent,
    output logic [15:0]              timeout_cnt,
`endif
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int HOLD_W = $clog2(START_HOLD + 1);
    localparam int TMO_W  = $clog2(START_TIMEOUT);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [DBITS-1:0]  head;
    logic              push;
    logic              pop;
    logic              tmo_hit;

    feeder_state_t     state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              tx_start_q;
    logic [DBITS-1:0]  tx_data_q;
    logic              timeout_err_q;

    assign push    = wr_valid && !fifo_full;
    assign pop     = (state_q == START) && tx_on;
    assign tmo_hit = (state_q == START) && !tx_on && (tmo_cnt_q == TMO_LAST);

    sync_fifo #(
        .W     (DBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_data),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !tx_on) begin
                        tx_data_q  <= head;
                        hold_cnt_q <= '0;
                        tmo_cnt_q  <= '0;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tx_start_q && (hold_cnt_q != HOLD_LAST)) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    tx_start_q <= tx_start_q && (hold_cnt_q != HOLD_LAST);
                    if (tx_on) begin
                        tx_start_q <= 1'b0;
                        state_q    <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        // Byte stays at the FIFO head so the next launch retries it.
                        tx_start_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    tx_start_q <= 1'b0;
                    if (!tx_on) begin
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign wr_ready    = !fifo_full;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;

`ifdef UART_TX_FEEDER_STATS_EN
    logic [31:0] bytes_sent_q;
    logic [15:0] timeout_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_sent_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (pop) begin
                bytes_sent_q <= bytes_sent_q + 1'b1;
            end
            if (tmo_hit && (timeout_cnt_q != 16'hFFFF)) begin
                timeout_cnt_q <= timeout_cnt_q + 1'b1;
            end
        end
    end

    assign bytes_sent  = bytes_sent_q;
    assign timeout_cnt = timeout_cnt_q;
`endif

endmodule
